// File: rtl/hack_cpu_pkg.sv
// Shared types and instruction-field positions for the multi-cycle-memory Hack core.
package hack_cpu_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXEC    = 2'd1,
      RD_WAIT = 2'd2,
      WR_WAIT = 2'd3
   } state_t;

   localparam int unsigned INST_W    = 16;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned BIT_CINST = 15;
   localparam int unsigned BIT_AM    = 12;
   localparam int unsigned ALU_FN_HI = 11;
   localparam int unsigned ALU_FN_LO = 6;
   localparam int unsigned DEST_HI   = 5;
   localparam int unsigned DEST_LO   = 3;
   localparam int unsigned JUMP_HI   = 2;
   localparam int unsigned JUMP_LO   = 0;

   // Standard Hack ALU control bits, msb first
   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_fn_t;

   typedef struct packed {
      logic a;
      logic d;
      logic m;
   } dest_t;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } jump_t;

   // Jump condition against the ALU result flags
   function automatic logic jump_taken(input jump_t j, input logic zr, input logic ng);
      return (j.lt & ng) | (j.eq & zr) | (j.gt & ~zr & ~ng);
   endfunction

endpackage

// File: rtl/hack_alu16.sv
// Combinational 16-bit Hack ALU with zero and negative flags.
module hack_alu16
   import hack_cpu_pkg::*;
(
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [5:0]  fn,
   output logic [15:0] res_c,
   output logic        zr_c,
   output logic        ng_c
);

   alu_fn_t     ctl;
   logic [15:0] x_z;
   logic [15:0] x_n;
   logic [15:0] y_z;
   logic [15:0] y_n;
   logic [15:0] f_out;

   // Zero/negate each operand, add or and, optionally negate the result
   always_comb begin
      ctl   = fn;
      x_z   = ctl.zx ? 16'h0000 : x;
      x_n   = ctl.nx ? ~x_z : x_z;
      y_z   = ctl.zy ? 16'h0000 : y;
      y_n   = ctl.ny ? ~y_z : y_z;
      f_out = ctl.f ? (x_n + y_n) : (x_n & y_n);
      res_c = ctl.no ? ~f_out : f_out;
      zr_c  = (res_c == 16'h0000);
      ng_c  = res_c[15];
   end

endmodule

// File: rtl/hack_cpu_mw.sv
// Hack core executing packed 32-bit fetch words over valid/ready instruction
// and data memories, with a one-entry fetch buffer.
// Build option: define CPU_DUAL_ISSUE_EN to pair an A-instruction in slot0
// with a C-instruction in slot1 and retire both in one step.
module hack_cpu_mw
   import hack_cpu_pkg::*;
#(
   parameter int unsigned PC_WIDTH = 12,
   parameter int unsigned DATA_AW  = 15
)(
   input  logic                clk,
   input  logic                reset,
   output logic                inst_req,
   output logic [PC_WIDTH-2:0] inst_addr,
   input  logic                inst_valid,
   input  logic [WORD_W-1:0]   inst,
   output logic                read_m,
   input  logic                m_rvalid,
   input  logic [INST_W-1:0]   in_m,
   output logic                write_m,
   input  logic                m_wready,
   output logic [INST_W-1:0]   out_m,
   output logic [DATA_AW-1:0]  data_addr
);

   state_t                state;
   logic [PC_WIDTH-1:0]   pc;
   logic [INST_W-1:0]     a_reg;
   logic [INST_W-1:0]     d_reg;
   logic [WORD_W-1:0]     fbuf;
   logic [PC_WIDTH-2:0]   fbuf_tag;
   logic                  fbuf_valid;

   logic [INST_W-1:0]     slot0;
   logic [INST_W-1:0]     slot1;
   logic [INST_W-1:0]     cur;
   logic                  dual;
   logic                  is_c;
   logic                  y_is_m;
   logic                  dest_m;
   dest_t                 dest;
   jump_t                 jmp;
   logic [5:0]            fn_bits;
   logic [INST_W-1:0]     a_eff;
   logic [INST_W-1:0]     alu_y;
   logic [INST_W-1:0]     alu_res;
   logic                  alu_zr;
   logic                  alu_ng;
   logic [INST_W-1:0]     res;
   logic                  res_zr;
   logic                  res_ng;
   logic                  jump;
   logic [PC_WIDTH-1:0]   pc_inc;
   logic [PC_WIDTH-1:0]   new_pc;
   logic [INST_W-1:0]     new_a;
   logic [INST_W-1:0]     new_d;
   logic                  buf_hit;
   logic                  retire;

   hack_alu16 u_alu (
      .x     (d_reg),
      .y     (alu_y),
      .fn    (fn_bits),
      .res_c (alu_res),
      .zr_c  (alu_zr),
      .ng_c  (alu_ng)
   );

   // Decode the executing slot and precompute the retirement results
   always_comb begin
      slot0 = fbuf[INST_W-1:0];
      slot1 = fbuf[WORD_W-1:INST_W];
`ifdef CPU_DUAL_ISSUE_EN
      dual  = ~pc[0] & ~slot0[BIT_CINST] & slot1[BIT_CINST];
`else
      dual  = 1'b0;
`endif
      cur     = (dual | pc[0]) ? slot1 : slot0;
      // In a pair the slot0 immediate is the A the C-instruction sees
      a_eff   = dual ? {1'b0, slot0[BIT_CINST-1:0]} : a_reg;
      is_c    = cur[BIT_CINST];
      fn_bits = cur[ALU_FN_HI:ALU_FN_LO];
      dest    = cur[DEST_HI:DEST_LO];
      jmp     = cur[JUMP_HI:JUMP_LO];
      y_is_m  = is_c & cur[BIT_AM];
      dest_m  = is_c & dest.m;
      alu_y   = cur[BIT_AM] ? in_m : a_eff;

      // While a write is pending the read operand is gone; out_m holds the result
      if (state == WR_WAIT) begin
         res    = out_m;
         res_zr = (out_m == 16'h0000);
         res_ng = out_m[INST_W-1];
      end else begin
         res    = alu_res;
         res_zr = alu_zr;
         res_ng = alu_ng;
      end

      jump    = is_c & jump_taken(jmp, res_zr, res_ng);
      pc_inc  = dual ? PC_WIDTH'(2) : PC_WIDTH'(1);
      new_pc  = jump ? a_eff[PC_WIDTH-1:0] : (pc + pc_inc);
      new_a   = ~is_c ? {1'b0, cur[BIT_CINST-1:0]} : (dest.a ? res : a_eff);
      new_d   = (is_c & dest.d) ? res : d_reg;
      buf_hit = fbuf_valid & (new_pc[PC_WIDTH-1:1] == fbuf_tag);

      retire  = ((state == EXEC)    & ~y_is_m & ~dest_m)
              | ((state == RD_WAIT) & read_m & m_rvalid & ~dest_m)
              | ((state == WR_WAIT) & write_m & m_wready);
   end

   // Control FSM with registered memory handshakes and architectural state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= FETCH;
         pc         <= '0;
         a_reg      <= '0;
         d_reg      <= '0;
         fbuf       <= '0;
         fbuf_tag   <= '0;
         fbuf_valid <= 1'b0;
         inst_req   <= 1'b0;
         inst_addr  <= '0;
         read_m     <= 1'b0;
         write_m    <= 1'b0;
         out_m      <= '0;
         data_addr  <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (!inst_req) begin
                  inst_req  <= 1'b1;
                  inst_addr <= pc[PC_WIDTH-1:1];
               end else if (inst_valid) begin
                  inst_req   <= 1'b0;
                  fbuf       <= inst;
                  fbuf_tag   <= inst_addr;
                  fbuf_valid <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (y_is_m) begin
                  read_m    <= 1'b1;
                  data_addr <= a_eff[DATA_AW-1:0];
                  state     <= RD_WAIT;
               end else if (dest_m) begin
                  out_m     <= alu_res;
                  write_m   <= 1'b1;
                  data_addr <= a_eff[DATA_AW-1:0];
                  state     <= WR_WAIT;
               end
            end
            RD_WAIT: begin
               if (read_m && m_rvalid) begin
                  read_m <= 1'b0;
                  if (dest_m) begin
                     out_m   <= alu_res;
                     write_m <= 1'b1;
                     state   <= WR_WAIT;
                  end
               end
            end
            WR_WAIT: begin
               if (write_m && m_wready) begin
                  write_m <= 1'b0;
               end
            end
            default: state <= FETCH;
         endcase

         if (retire) begin
            a_reg <= new_a;
            d_reg <= new_d;
            pc    <= new_pc;
            if (buf_hit) begin
               state <= EXEC;
            end else begin
               state     <= FETCH;
               inst_req  <= 1'b1;
               inst_addr <= new_pc[PC_WIDTH-1:1];
            end
         end
      end
   end

endmodule
